led_seq_ctrl: RTL and testbench
===============================

// Module: led_seq_ctrl
// PURPOSE
//   Controller for the 4-LED pattern display.
//   - Conditions the two raw pushbuttons: synchronise, debounce, edge-detect.
//   - Holds the mode and speed configuration.
//   - Generates the step tick and drives the one-hot LED position.
//   Replaces ad-hoc button/timer logic in the top level; the top instantiates it
//   between the board pins and the LEDs.
// PARAMETERS
//   TICK_CYCLES_1S   125_000_000  clk cycles per 1 s step; sims override (e.g. 125_000)
//   SLOW_MULT        3            step-period multiplier in slow mode (3 s)
//   DEBOUNCE_CYCLES  1_250_000    cycles a synced button level must be stable (10 ms @125 MHz)
// PORTS
//   clk        in   1  system clock, 125 MHz, rising edge
//   rst        in   1  synchronous, active-high reset
//   btn0       in   1  raw async button, mode toggle, active-high
//   btn1       in   1  raw async button, speed toggle, active-high
//   leds       out  4  one-hot LED drive
//   mode       out  1  0 = Mode A (bounce), 1 = Mode B (rotate)
//   speed      out  1  0 = 1 s step, 1 = SLOW_MULT s step
//   step_tick  out  1  1-cycle pulse in the cycle the position advances
// BEHAVIOUR
//   Reset (rst=1 at a clk edge), all values at that edge:
//     mode=0, speed=0, pos=0, leds=4'b0001, tick counter=0, step_tick=0;
//     sync flops, debounced levels and debounce counters cleared.
//   Button path, per button:
//     - 2-flop synchroniser.
//     - Debounce counter restarts whenever the synced level differs from the
//       debounced level; the debounced level takes the new value after
//       DEBOUNCE_CYCLES consecutive differing cycles.
//     - A 0->1 change of the debounced level gives one 1-cycle press pulse.
//     - Release and holding generate nothing.
//     - Worst-case press latency from raw edge: DEBOUNCE_CYCLES+4 cycles.
//   Tick counter:
//     - Width $clog2(SLOW_MULT*TICK_CYCLES_1S).
//     - PERIOD = TICK_CYCLES_1S when speed=0, SLOW_MULT*TICK_CYCLES_1S when speed=1.
//     - Counts 0..PERIOD-1. In the cycle count==PERIOD-1: step_tick=1; at that
//       edge the count wraps to 0 and pos advances.
//   Position FSM (pos register, 3 bits):
//     - Mode A: pos 0..5 -> leds 0001,0010,0100,1000,0100,0010; next=(pos+1)%6.
//     - Mode B: pos 0..3 -> leds 0001,0010,0100,1000; next=(pos+1)%4.
//     - leds is a registered decode of pos; it changes on the same edge as pos.
//   btn0 press: at the next edge, mode toggles, pos=0 (leds=0001), count=0.
//   btn1 press: at the next edge, speed toggles, count=0; pos and mode unchanged.
//   Both presses in the same cycle: both take effect (mode and speed toggle,
//     pos=0, count=0).
//   Press in the terminal-count cycle: the press wins; step_tick=0, pos does not
//     advance, count=0.
//   Changing speed mid-period discards the elapsed count; the next step comes one
//     full new PERIOD later.
//   rst mid-operation overrides everything in the same edge, including pending
//     presses and debounce progress.
// TESTING  (TICK_CYCLES_1S=10, SLOW_MULT=3, DEBOUNCE_CYCLES=4)
//   1. Release rst, no buttons -> leds 0001,0010,0100,1000,0100,0010,0001 at 10-cycle
//      spacing; step_tick high 1 cycle per step.
//   2. btn0 high for 10 cycles -> within 8 cycles mode=1, leds=0001; then
//      0010,0100,1000,0001 every 10 cycles.
//   3. btn1 pulse of 10 cycles -> speed=1, steps every 30 cycles; second press ->
//      back to 10-cycle steps.
//   4. btn0 glitch of 2 cycles, then btn0 held 100 cycles -> glitch ignored;
//      exactly one mode toggle.
//   5. btn0+btn1 pressed together, debounced press landing on count==9 ->
//      mode and speed toggle, leds=0001, no step_tick that cycle.
//   6. rst during Mode B, speed=1, leds=1000 -> next cycle leds=0001, mode=0,
//      speed=0, first step 10 cycles after rst drops.

Source files
------------

// File: rtl/led_seq_ctrl.sv
// LED pattern controller: conditions two pushbuttons, holds mode/speed, and steps
// a one-hot LED position on a configurable period (bounce or rotate pattern).
module led_seq_ctrl #(
  parameter int TICK_CYCLES_1S  = 125_000_000,
  parameter int SLOW_MULT       = 3,
  parameter int DEBOUNCE_CYCLES = 1_250_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn0,
  input  logic       btn1,
  output logic [3:0] leds,
  output logic       mode,
  output logic       speed,
  output logic       step_tick
);

  localparam int SLOW_CYCLES = SLOW_MULT * TICK_CYCLES_1S;
  localparam int CW = $clog2(SLOW_CYCLES);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] FAST_LAST = CW'(TICK_CYCLES_1S - 1);
  localparam logic [CW-1:0] SLOW_LAST = CW'(SLOW_CYCLES - 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    POS_0 = 3'd0,
    POS_1 = 3'd1,
    POS_2 = 3'd2,
    POS_3 = 3'd3,
    POS_4 = 3'd4,
    POS_5 = 3'd5
  } pos_t;

  // Button conditioning; bit 0 is btn0 (mode), bit 1 is btn1 (speed).
  logic [1:0]    btn_raw;
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    deb;
  logic [1:0]    deb_q;
  logic [1:0]    press;
  logic [DW-1:0] db_cnt [2];

  assign btn_raw = {btn1, btn0};

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_q <= '0;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      deb_q <= deb;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          deb[i]    <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DW'(1);
        end
      end
    end
  end

  assign press = deb & ~deb_q;

  // Step timer and position state.
  pos_t          pos;
  pos_t          pos_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [CW-1:0] cnt_last;
  logic          mode_nxt;
  logic          speed_nxt;
  logic [3:0]    leds_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      pos   <= POS_0;
      cnt   <= '0;
      mode  <= 1'b0;
      speed <= 1'b0;
      leds  <= 4'b0001;
    end else begin
      pos   <= pos_nxt;
      cnt   <= cnt_nxt;
      mode  <= mode_nxt;
      speed <= speed_nxt;
      leds  <= leds_nxt;
    end
  end

  always_comb begin
    cnt_last  = speed ? SLOW_LAST : FAST_LAST;
    pos_nxt   = pos;
    cnt_nxt   = cnt + CW'(1);
    mode_nxt  = mode;
    speed_nxt = speed;
    step_tick = 1'b0;
    leds_nxt  = 4'b0001;
    // A press restarts the period and takes priority over a terminal count.
    if (press[0] || press[1]) begin
      cnt_nxt = '0;
      if (press[0]) begin
        mode_nxt = ~mode;
        pos_nxt  = POS_0;
      end
      if (press[1]) speed_nxt = ~speed;
    end else if (cnt == cnt_last) begin
      cnt_nxt   = '0;
      step_tick = ~rst;
      case (pos)
        POS_0:   pos_nxt = POS_1;
        POS_1:   pos_nxt = POS_2;
        POS_2:   pos_nxt = POS_3;
        POS_3:   pos_nxt = mode ? POS_0 : POS_4;
        POS_4:   pos_nxt = POS_5;
        default: pos_nxt = POS_0;
      endcase
    end
    case (pos_nxt)
      POS_0:   leds_nxt = 4'b0001;
      POS_1:   leds_nxt = 4'b0010;
      POS_2:   leds_nxt = 4'b0100;
      POS_3:   leds_nxt = 4'b1000;
      POS_4:   leds_nxt = 4'b0100;
      POS_5:   leds_nxt = 4'b0010;
      default: leds_nxt = 4'b0001;
    endcase
  end

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Directed bench for led_seq_ctrl with short periods (tick 10, slow x3, debounce 4).
module tb_led_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn0;
  logic       btn1;
  logic [3:0] leds;
  logic       mode;
  logic       speed;
  logic       step_tick;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  led_seq_ctrl #(
    .TICK_CYCLES_1S (10),
    .SLOW_MULT      (3),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn0     (btn0),
    .btn1     (btn1),
    .leds     (leds),
    .mode     (mode),
    .speed    (speed),
    .step_tick(step_tick)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Sample point: 1 time unit after the rising edge.
  task automatic tick_wait();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_btn(input int which, input int len);
    if (which == 0) btn0 = 1'b1;
    else            btn1 = 1'b1;
    repeat (len) tick_wait();
    if (which == 0) btn0 = 1'b0;
    else            btn1 = 1'b0;
  endtask

  // Called with the tick count at 0; checks one full period and the advance.
  task automatic do_step(input int period, input logic [3:0] prev, input logic [3:0] nxt,
                         input string tag);
    int early;
    early = 0;
    repeat (period - 2) begin
      tick_wait();
      if (step_tick) early++;
    end
    check($sformatf("%s_early", tag), early, 0);
    tick_wait();
    check($sformatf("%s_tick_hi", tag), step_tick, 1);
    check($sformatf("%s_leds_prev", tag), leds, prev);
    tick_wait();
    check($sformatf("%s_leds_next", tag), leds, nxt);
    check($sformatf("%s_tick_lo", tag), step_tick, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] seq_a [6];
    logic [3:0] seq_b [4];
    logic [3:0] seq_c [11];
    logic [3:0] prev;
    seq_a = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001};
    seq_b = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    seq_c = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001,
              4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010};

    rst  = 1'b1;
    btn0 = 1'b0;
    btn1 = 1'b0;
    repeat (2) tick_wait();
    rst = 1'b0;
    check("rst_leds", leds, 4'b0001);
    check("rst_mode", mode, 0);
    check("rst_speed", speed, 0);
    check("rst_tick", step_tick, 0);

    // Mode A bounce at 10-cycle steps.
    prev = 4'b0001;
    for (int i = 0; i < 6; i++) begin
      do_step(10, prev, seq_a[i], $sformatf("t1_s%0d", i));
      prev = seq_a[i];
    end

    // Mode toggle: press effect lands 7 edges after the raw rise.
    fork drive_btn(0, 10); join_none
    repeat (6) tick_wait();
    check("t2_mode_pre", mode, 0);
    tick_wait();
    check("t2_mode", mode, 1);
    check("t2_leds", leds, 4'b0001);
    check("t2_tick", step_tick, 0);
    prev = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      do_step(10, prev, seq_b[i], $sformatf("t2_s%0d", i));
      prev = seq_b[i];
    end

    // Speed toggle to slow and back; elapsed count is discarded.
    fork drive_btn(1, 10); join_none
    repeat (6) tick_wait();
    check("t3_speed_pre", speed, 0);
    tick_wait();
    check("t3_speed", speed, 1);
    check("t3_mode", mode, 1);
    check("t3_leds", leds, 4'b0001);
    do_step(30, 4'b0001, 4'b0010, "t3_slow0");
    do_step(30, 4'b0010, 4'b0100, "t3_slow1");
    fork drive_btn(1, 10); join_none
    repeat (6) tick_wait();
    check("t3_speed2_pre", speed, 1);
    tick_wait();
    check("t3_speed2", speed, 0);
    check("t3_leds2", leds, 4'b0100);
    do_step(10, 4'b0100, 4'b1000, "t3_fast");

    // Glitch of 2 cycles is ignored; long hold toggles mode exactly once.
    fork drive_btn(0, 2); join_none
    repeat (5) tick_wait();
    fork drive_btn(0, 100); join_none
    repeat (6) tick_wait();
    check("t4_glitch_ignored", mode, 1);
    check("t4_wrap_leds", leds, 4'b0001);
    tick_wait();
    check("t4_mode", mode, 0);
    check("t4_leds", leds, 4'b0001);
    prev = 4'b0001;
    for (int i = 0; i < 11; i++) begin
      do_step(10, prev, seq_c[i], $sformatf("t4_s%0d", i));
      prev = seq_c[i];
    end
    check("t4_one_toggle", mode, 0);

    // Both buttons together, press lands on the terminal-count cycle.
    repeat (3) tick_wait();
    fork
      drive_btn(0, 10);
      drive_btn(1, 10);
    join_none
    repeat (6) tick_wait();
    check("t5_no_tick", step_tick, 0);
    check("t5_leds_hold", leds, 4'b0010);
    tick_wait();
    check("t5_mode", mode, 1);
    check("t5_speed", speed, 1);
    check("t5_leds", leds, 4'b0001);
    check("t5_tick", step_tick, 0);
    do_step(30, 4'b0001, 4'b0010, "t5_s0");
    do_step(30, 4'b0010, 4'b0100, "t5_s1");
    do_step(30, 4'b0100, 4'b1000, "t5_s2");

    // Reset mid-period in Mode B, slow, leds=1000.
    repeat (5) tick_wait();
    rst = 1'b1;
    tick_wait();
    check("t6_leds", leds, 4'b0001);
    check("t6_mode", mode, 0);
    check("t6_speed", speed, 0);
    check("t6_tick", step_tick, 0);
    rst = 1'b0;
    do_step(10, 4'b0001, 4'b0010, "t6_first");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
